// File: rtl/ctrl_pkg.sv
// Shared definitions for the pulse-width-coded counter control line.
// Both the encoder and the downstream counter decoder import this package,
// so the command encoding and pulse widths always stay in step.
package ctrl_pkg;

  // Command encoding carried on the 2-bit command bus
  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_DOWN  = 2'b01,
    CMD_UP    = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_t;

  // Default pulse widths (cycles of ctrl high) for each command
  localparam int W_RESET = 1;
  localparam int W_DOWN  = 2;
  localparam int W_UP    = 3;

  // Default queue depth and minimum low gap after a pulse
  localparam int DEF_DEPTH = 4;
  localparam int DEF_GAP   = 2;

  // Pulse width that encodes a command; reserved commands produce no pulse
  function automatic int width_of(input cmd_t c);
    int w;
    case (c)
      CMD_RESET: w = W_RESET;
      CMD_DOWN:  w = W_DOWN;
      CMD_UP:    w = W_UP;
      default:   w = 0;
    endcase
    return w;
  endfunction

  // Larger of two integers, used to size down-counters
  function automatic int max_of(input int a, input int b);
    int m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// DEPTH x 2-bit synchronous command FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. No bypass: a word written on one
// edge can be read out on the following edge at the earliest.
module ctrl_cmd_fifo
  import ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance read/write pointers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= {(AW + 1){1'b0}};
      rd_ptr <= {(AW + 1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ctrl_pulse_encoder.sv
// Upstream driver for the pulse-width-coded counter control line.
// Commands arrive over valid/ready into a small FIFO, then are serialised
// one at a time onto 'ctrl' as a high pulse whose length encodes the
// command, followed by a guaranteed low gap so the counter can decode each
// pulse on its falling edge. Reserved commands are flagged and dropped.
module ctrl_pulse_encoder
  import ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP     = DEF_GAP,
  parameter int W_RESET = width_of(CMD_RESET),
  parameter int W_DOWN  = width_of(CMD_DOWN),
  parameter int W_UP    = width_of(CMD_UP)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       ctrl,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Counter must hold the longest pulse or gap minus one
  localparam int MAXW = max_of(max_of(W_UP, GAP), max_of(W_DOWN, W_RESET));
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          cmd_in;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          ctrl_next;
  logic          done_next;

  // Counter preload for a command: its pulse width minus one
  function automatic logic [CW-1:0] load_of(input cmd_t c);
    logic [CW-1:0] v;
    case (c)
      CMD_RESET: v = CW'(W_RESET - 1);
      CMD_DOWN:  v = CW'(W_DOWN - 1);
      CMD_UP:    v = CW'(W_UP - 1);
      default:   v = CNT_ZERO;
    endcase
    return v;
  endfunction

  assign cmd_in = cmd_t'(cmd);
  assign push   = cmd_valid && !full;

  ctrl_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Pulse sequencer: pop a command, hold ctrl high for its width, then hold low for the gap
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctrl_next  = 1'b0;
    done_next  = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == CMD_RSVD) begin
            state_next = ST_IDLE;
          end else begin
            ctrl_next  = 1'b1;
            cnt_next   = load_of(head);
            state_next = ST_PULSE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (cnt == CNT_ZERO) begin
          ctrl_next  = 1'b0;
          cnt_next   = GAP_LOAD;
          state_next = ST_GAP;
        end else begin
          ctrl_next  = 1'b1;
          cnt_next   = cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == CNT_ZERO) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state and registered line outputs; reset drops ctrl at once
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= CNT_ZERO;
      ctrl  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ctrl  <= ctrl_next;
      done  <= done_next;
    end
  end

  // Sticky flag raised when a reserved command is accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (push && (cmd_in == CMD_RSVD)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_ctrl_pulse_encoder.sv
// Scoreboard bench for ctrl_pulse_encoder.
// The reference model schedules each accepted command on a timeline:
// a command can start no earlier than the edge after it is accepted and no
// earlier than the engine frees up (pulse + gap + one idle edge). Expected
// pulses are queued; an independent monitor pops them as ctrl rises.
module tb_ctrl_pulse_encoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       ctrl;
  logic       busy;
  logic       done;
  logic       err;

  ctrl_pulse_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    int rise;
    int w;
  } exp_t;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // model state
  exp_t exp_q[$];
  int   pops[$];
  int   pend_done[$];
  int   free_edge = 0;
  int   active_until = 0;
  logic err_exp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: value after edge e equals e
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int pulse_w(input logic [1:0] c);
    if (c == 2'b00) return 1;
    if (c == 2'b01) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pops.delete();
    free_edge = 0;
    active_until = 0;
    err_exp = 1'b0;
  endtask

  task automatic model_accept(input logic [1:0] c, input int e);
    int   p;
    exp_t x;
    p = (e + 1 > free_edge) ? e + 1 : free_edge;
    pops.push_back(p);
    if (c == 2'b11) begin
      err_exp = 1'b1;
      free_edge = p + 1;
    end else begin
      x.rise = p;
      x.w = pulse_w(c);
      exp_q.push_back(x);
      free_edge = p + x.w + GAP + 1;
      active_until = p + x.w + GAP;
    end
  endtask

  // One bench cycle: drive at negedge, apply model at edge, check status outputs
  task automatic drive_cycle(input logic v, input logic [1:0] c, input logic r);
    logic rdy;
    int   e;
    @(negedge clk);
    rst = r;
    cmd_valid = v;
    cmd = c;
    rdy = cmd_ready;
    @(posedge clk);
    #1;
    e = cyc;
    if (!r) begin
      model_reset();
    end else if (v && rdy) begin
      model_accept(c, e);
    end
    while (pops.size() > 0 && pops[0] <= e) void'(pops.pop_front());
    chk("cmd_ready", int'(cmd_ready), int'(pops.size() < DEPTH));
    chk("busy", int'(busy), int'((pops.size() > 0) || (e < active_until)));
    chk("err", int'(err), int'(err_exp));
  endtask

  // Monitor: match ctrl pulses and done strobes against the expected queue
  initial begin : monitor
    logic prev;
    int   run;
    int   cur_w;
    int   cur_rise;
    int   e;
    exp_t x;
    prev = 1'b0;
    run = 0;
    cur_w = 0;
    cur_rise = 0;
    forever begin
      @(posedge clk);
      #2;
      e = cyc;
      if (!rst) begin
        chk("ctrl_in_reset", int'(ctrl), 0);
        chk("done_in_reset", int'(done), 0);
        pend_done.delete();
        prev = 1'b0;
        run = 0;
      end else begin
        if (ctrl && !prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
            cur_w = 0;
            cur_rise = e;
          end else begin
            x = exp_q.pop_front();
            chk("pulse_start_edge", e, x.rise);
            cur_w = x.w;
            cur_rise = x.rise;
          end
          run = 1;
        end else if (ctrl && prev) begin
          run++;
        end else if (!ctrl && prev) begin
          chk("pulse_width", run, cur_w);
          pend_done.push_back(cur_rise + cur_w + GAP);
        end
        if (pend_done.size() > 0 && pend_done[0] < e) begin
          chk("done_missing", e, pend_done[0]);
          void'(pend_done.pop_front());
        end
        if (done) begin
          if (pend_done.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("done_edge", e, pend_done.pop_front());
          end
        end
        prev = ctrl;
      end
    end
  end

  initial begin : stimulus
    logic [1:0] seq3[4];
    seq3[0] = 2'b10; seq3[1] = 2'b10; seq3[2] = 2'b01; seq3[3] = 2'b10;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd = 2'b00;

    // 1: reset held, then idle
    repeat (10) drive_cycle(1'b0, 2'b00, 1'b0);
    repeat (5) drive_cycle(1'b0, 2'b00, 1'b1);

    // 2: single commands from idle
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 2'(c), 1'b1);
      repeat (10) drive_cycle(1'b0, 2'b00, 1'b1);
    end

    // 3: UP, UP, DOWN, UP back-to-back
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, seq3[i], 1'b1);
    repeat (30) drive_cycle(1'b0, 2'b00, 1'b1);

    // 4: reserved command between two UPs
    drive_cycle(1'b1, 2'b10, 1'b1);
    drive_cycle(1'b1, 2'b11, 1'b1);
    drive_cycle(1'b1, 2'b10, 1'b1);
    repeat (25) drive_cycle(1'b0, 2'b00, 1'b1);

    // 5: reset during second cycle of an UP pulse with two queued
    repeat (3) drive_cycle(1'b1, 2'b10, 1'b1);
    repeat (3) drive_cycle(1'b0, 2'b00, 1'b0);
    repeat (20) drive_cycle(1'b0, 2'b00, 1'b1);

    // 6: hold valid through full FIFO while pops occur
    for (int i = 0; i < 60; i++) drive_cycle(1'b1, 2'($urandom_range(0, 2)), 1'b1);
    repeat (40) drive_cycle(1'b0, 2'b00, 1'b1);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
    end

    // drain
    repeat (60) drive_cycle(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("pulses_outstanding", exp_q.size(), 0);
    chk("done_outstanding", pend_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
